// File: rtl/wishbone_config_loader_pkg.sv
// Shared constants for the Wishbone configuration loader: register map,
// STATUS bit positions, CTRL field positions and the loader FSM states.
package fpga250_cfg_pkg;

  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_DATA     = 8'h08;
  localparam logic [7:0] REG_READBACK = 8'h0C;

  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_EMPTY     = 3;
  localparam int ST_OVF       = 4;
  localparam int ST_ERR       = 5;
  localparam int ST_LEVEL_LSB = 8;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 8;
  localparam int CTRL_SEL_LSB = 4;
  localparam int CTRL_CNT_LSB = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_STALL,
    S_LATCH
  } cfg_state_e;

endpackage

// File: rtl/wishbone_config_loader_if.sv
// Wishbone slave bus bundle for the configuration loader; the master modport
// is the management-core side, the slave modport is the loader side.
interface wishbone_config_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wishbone_config_loader_fifo.sv
// Synchronous word FIFO feeding the shift engine. A push into a full FIFO is
// accepted when a pop happens in the same cycle; flush empties it at once.
module cfg_word_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wishbone_config_loader.sv
// Wishbone slave that streams FIFO-buffered config words LSB-first into one of
// NUM_CHAINS serial shift chains. Define CFG_READBACK_EN to add the tail-capture register.
module wishbone_config_loader
  import fpga250_cfg_pkg::*;
#(
  parameter int          NUM_CHAINS = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  wishbone_config_loader_if.slave wb,
`ifdef CFG_READBACK_EN
  input  logic [NUM_CHAINS-1:0] cfg_tail_i,
`endif
  output logic [NUM_CHAINS-1:0] cfg_data_o,
  output logic [NUM_CHAINS-1:0] cfg_shift_o,
  output logic [NUM_CHAINS-1:0] cfg_set_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  cfg_state_e   state_q, state_d;
  logic [3:0]   sel_q, sel_d;
  logic [15:0]  remaining_q, remaining_d;
  logic [5:0]   word_left_q, word_left_d;
  logic [31:0]  sreg_q, sreg_d;
  logic [3:0]   ctrl_sel_q;
  logic [15:0]  ctrl_cnt_q;
  logic         done_q, ovf_q, err_q;
  logic         ack_q;
  logic [31:0]  dat_o_q;

  logic         req, wr_ctrl, wr_status, wr_data, rd_req;
  logic         start_req, abort_req, start_ok, start_bad;
  logic [3:0]   new_sel;
  logic [15:0]  new_cnt;
  logic         fifo_pop, fifo_full, fifo_empty;
  logic [31:0]  fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic         shift_en, set_en;
  logic [31:0]  status_w, rdata_w;
  logic         unused_sel;

  assign unused_sel = &{1'b0, wb.wbs_sel_i};

  // A request is gated by ack_q so a held strobe is acked only once.
  assign req = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q
             & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr_ctrl   = req & wb.wbs_we_i & (wb.wbs_adr_i[7:0] == REG_CTRL);
  assign wr_status = req & wb.wbs_we_i & (wb.wbs_adr_i[7:0] == REG_STATUS);
  assign wr_data   = req & wb.wbs_we_i & (wb.wbs_adr_i[7:0] == REG_DATA);
  assign rd_req    = req & ~wb.wbs_we_i;

  assign new_sel   = wb.wbs_dat_i[CTRL_SEL_LSB +: 4];
  assign new_cnt   = wb.wbs_dat_i[CTRL_CNT_LSB +: 16];
  assign abort_req = wr_ctrl & wb.wbs_dat_i[CTRL_ABORT];
  assign start_req = wr_ctrl & wb.wbs_dat_i[CTRL_START] & ~abort_req & (state_q == S_IDLE);
  assign start_ok  = start_req & (new_cnt != 16'd0) & ({1'b0, new_sel} < 5'(NUM_CHAINS));
  assign start_bad = start_req & ~start_ok;

  cfg_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .flush_i (abort_req),
    .push_i  (wr_data),
    .wdata_i (wb.wbs_dat_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // The last bit of a word refills the shift register directly, avoiding a LOAD bubble.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    if (abort_req) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start_ok) state_d = S_LOAD;
        S_LOAD: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = S_SHIFT;
          end else begin
            state_d = S_STALL;
          end
        end
        S_SHIFT: begin
          if (remaining_q == 16'd1) begin
            state_d = S_LATCH;
          end else if (word_left_q == 6'd1) begin
            if (!fifo_empty) fifo_pop = 1'b1;
            else             state_d  = S_LOAD;
          end
        end
        S_STALL: if (!fifo_empty) state_d = S_LOAD;
        S_LATCH: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en = (state_q == S_SHIFT);
    set_en   = (state_q == S_LATCH);
    busy_o   = (state_q != S_IDLE);
  end

  for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_chain
    logic hit;
    assign hit             = (sel_q == 4'(gi));
    assign cfg_shift_o[gi] = shift_en & hit;
    assign cfg_data_o[gi]  = shift_en & hit & sreg_q[0];
    assign cfg_set_o[gi]   = set_en & hit;
  end

  always_comb begin
    sel_d       = sel_q;
    remaining_d = remaining_q;
    word_left_d = word_left_q;
    sreg_d      = sreg_q;
    if (start_ok) begin
      sel_d       = new_sel;
      remaining_d = new_cnt;
    end
    if (shift_en) begin
      sreg_d      = {1'b0, sreg_q[31:1]};
      remaining_d = remaining_q - 16'd1;
      word_left_d = word_left_q - 6'd1;
    end
    if (fifo_pop) begin
      sreg_d      = fifo_rdata;
      word_left_d = 6'd32;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      sel_q       <= '0;
      remaining_q <= '0;
      word_left_q <= '0;
      sreg_q      <= '0;
    end else begin
      sel_q       <= sel_d;
      remaining_q <= remaining_d;
      word_left_q <= word_left_d;
      sreg_q      <= sreg_d;
    end
  end

`ifdef CFG_READBACK_EN
  logic [31:0] rb_q;
  logic        tail_bit;

  always_comb begin
    tail_bit = 1'b0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (sel_q == 4'(i)) tail_bit = cfg_tail_i[i];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni)    rb_q <= '0;
    else if (start_ok) rb_q <= '0;
    else if (shift_en) rb_q <= {tail_bit, rb_q[31:1]};
  end
`endif

  always_comb begin
    status_w                      = '0;
    status_w[ST_BUSY]             = busy_o;
    status_w[ST_DONE]             = done_q;
    status_w[ST_FULL]             = fifo_full;
    status_w[ST_EMPTY]            = fifo_empty;
    status_w[ST_OVF]              = ovf_q;
    status_w[ST_ERR]              = err_q;
    status_w[ST_LEVEL_LSB +: 8]   = 8'(fifo_level);
  end

  always_comb begin
    rdata_w = '0;
    unique case (wb.wbs_adr_i[7:0])
      REG_CTRL:     rdata_w = {ctrl_cnt_q, 8'h00, ctrl_sel_q, 4'h0};
      REG_STATUS:   rdata_w = status_w;
`ifdef CFG_READBACK_EN
      REG_READBACK: rdata_w = rb_q;
`endif
      default:      rdata_w = '0;
    endcase
  end

  // Sticky bits: the set condition is applied after the W1C so a set wins.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      dat_o_q    <= '0;
      ctrl_sel_q <= '0;
      ctrl_cnt_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_q   <= req;
      dat_o_q <= rd_req ? rdata_w : 32'h0;
      if (wr_ctrl) begin
        ctrl_sel_q <= new_sel;
        ctrl_cnt_q <= new_cnt;
      end
      if (wr_status && wb.wbs_dat_i[ST_DONE]) done_q <= 1'b0;
      if (wr_status && wb.wbs_dat_i[ST_OVF])  ovf_q  <= 1'b0;
      if (wr_status && wb.wbs_dat_i[ST_ERR])  err_q  <= 1'b0;
      if (set_en)                              done_q <= 1'b1;
      if (wr_data && fifo_full && !fifo_pop)   ovf_q  <= 1'b1;
      if (start_bad)                           err_q  <= 1'b1;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_o_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_wishbone_config_loader.sv
// Directed bench for wishbone_config_loader (NUM_CHAINS=2, FIFO_DEPTH=8).
module tb_wishbone_config_loader;

  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_STATUS = 32'h3000_0004;
  localparam logic [31:0] A_DATA   = 32'h3000_0008;
  localparam logic [31:0] A_RB     = 32'h3000_000C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cfg_data, cfg_shift, cfg_set;
  logic       busy, done;

  int errors = 0;
  int checks = 0;

  int sh0, sh1, set0, set1, stray, cyc, first_c, last_c, bitn;
  logic [127:0] bits;
  logic [31:0]  rd;

  always #5 clk = ~clk;

  wishbone_config_loader_if bus ();

  wishbone_config_loader #(
    .NUM_CHAINS (2),
    .BASE_ADDR  (32'h3000_0000),
    .FIFO_DEPTH (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wb          (bus),
`ifdef CFG_READBACK_EN
    .cfg_tail_i  (2'b00),
`endif
    .cfg_data_o  (cfg_data),
    .cfg_shift_o (cfg_shift),
    .cfg_set_o   (cfg_set),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic exp_ack, output logic [31:0] rdat);
    logic got;
    got  = 1'b0;
    rdat = '0;
    @(negedge clk);
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        got  = 1'b1;
        rdat = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    if (we) $display("wb wr adr=%h dat=%h ack=%0b", adr, wdat, got);
    else    $display("wb rd adr=%h dat=%h ack=%0b", adr, rdat, got);
    chk("ack", {31'b0, got}, {31'b0, exp_ack});
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] unused_rd;
    xfer(1'b1, adr, d, 1'b1, unused_rd);
  endtask

  task automatic rdr(input logic [31:0] adr, output logic [31:0] d);
    xfer(1'b0, adr, 32'h0, 1'b1, d);
  endtask

  task automatic clr_mon();
    sh0 = 0; sh1 = 0; set0 = 0; set1 = 0; stray = 0;
    cyc = 0; first_c = -1; last_c = -1; bitn = 0; bits = '0;
  endtask

  task automatic mon(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cfg_shift[0]) sh0++;
      if (cfg_shift[1]) sh1++;
      if (|cfg_shift) begin
        if (bitn < 128) bits[bitn] = |(cfg_data & cfg_shift);
        bitn++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      if ((cfg_data & ~cfg_shift) != 2'b00) stray++;
      if (cfg_set[0]) set0++;
      if (cfg_set[1]) set1++;
    end
  endtask

  initial begin
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // reset state
    chk("rst_outs", {26'b0, cfg_data, cfg_shift, cfg_set}, 32'h0);
    chk("rst_busy_done", {30'b0, busy, done}, 32'h0);
    rdr(A_STATUS, rd);
    chk("rst_status", rd, 32'h0000_0008);
    @(posedge clk); #1;
    chk("ack_single", {31'b0, bus.wbs_ack_o}, 32'h0);

    // single 32-bit word into chain 1
    wr(A_DATA, 32'hA5A5_0F0F);
    wr(A_CTRL, 32'h0020_0011);
    clr_mon();
    mon(40);
    chk("t1_shifts", sh1, 32);
    chk("t1_other", sh0, 0);
    chk("t1_span", last_c - first_c + 1, 32);
    chk("t1_data", bits[31:0], 32'hA5A5_0F0F);
    chk("t1_set1", set1, 1);
    chk("t1_set0", set0, 0);
    chk("t1_stray", stray, 0);
    chk("t1_done_o", {31'b0, done}, 32'h1);
    rdr(A_STATUS, rd);
    chk("t1_status", rd, 32'h0000_000A);

    // 80 bits across three words, no gaps
    wr(A_DATA, 32'h89AB_CDEF);
    wr(A_DATA, 32'h0123_4567);
    wr(A_DATA, 32'hDEAD_BEEF);
    wr(A_CTRL, 32'h0050_0011);
    clr_mon();
    mon(90);
    chk("t2_shifts", sh1, 80);
    chk("t2_span", last_c - first_c + 1, 80);
    chk("t2_w0", bits[31:0], 32'h89AB_CDEF);
    chk("t2_w1", bits[63:32], 32'h0123_4567);
    chk("t2_w2", {16'h0, bits[79:64]}, 32'h0000_BEEF);
    chk("t2_set1", set1, 1);
    rdr(A_STATUS, rd);
    chk("t2_status", rd, 32'h0000_000A);

    // 64 bits with one word, stall, then second word on chain 0
    wr(A_STATUS, 32'h0000_0002);
    rdr(A_STATUS, rd);
    chk("t3_w1c_done", rd, 32'h0000_0008);
    wr(A_DATA, 32'h0000_FFFF);
    wr(A_CTRL, 32'h0040_0001);
    clr_mon();
    mon(40);
    chk("t3_shifts_a", sh0, 32);
    chk("t3_set_a", set0, 0);
    chk("t3_busy", {31'b0, busy}, 32'h1);
    rdr(A_STATUS, rd);
    chk("t3_stall_status", rd, 32'h0000_0009);
    mon(10);
    wr(A_DATA, 32'hF0F0_F0F0);
    clr_mon();
    mon(40);
    chk("t3_shifts_b", sh0, 32);
    chk("t3_data_b", bits[31:0], 32'hF0F0_F0F0);
    chk("t3_set_b", set0, 1);
    chk("t3_chain1", sh1 + set1, 0);

    // overflow on FIFO_DEPTH+1 pushes
    for (int i = 0; i < 9; i++) wr(A_DATA, 32'h1000_0000 + 32'(i));
    rdr(A_STATUS, rd);
    chk("t4_ovf_status", rd, 32'h0000_0816);
    wr(A_STATUS, 32'h0000_0010);
    rdr(A_STATUS, rd);
    chk("t4_w1c_ovf", rd, 32'h0000_0806);
    wr(A_CTRL, 32'h0000_0100);
    rdr(A_STATUS, rd);
    chk("t4_abort_flush", rd, 32'h0000_000A);

    // bad chain select and zero bit count
    wr(A_CTRL, 32'h0020_0031);
    clr_mon();
    mon(5);
    chk("t5_no_shift", sh0 + sh1, 0);
    chk("t5_busy", {31'b0, busy}, 32'h0);
    rdr(A_STATUS, rd);
    chk("t5_err_status", rd, 32'h0000_002A);
    rdr(A_CTRL, rd);
    chk("t5_ctrl_rd", rd, 32'h0020_0030);
    wr(A_STATUS, 32'h0000_0022);
    wr(A_CTRL, 32'h0000_0011);
    rdr(A_STATUS, rd);
    chk("t5_zero_cnt", rd, 32'h0000_0028);
    wr(A_STATUS, 32'h0000_0020);

    // abort mid-shift
    wr(A_DATA, 32'h1234_5678);
    wr(A_DATA, 32'h9ABC_DEF0);
    wr(A_CTRL, 32'h0040_0011);
    clr_mon();
    mon(5);
    chk("t6_shifting", sh1, 5);
    wr(A_CTRL, 32'h0000_0100);
    chk("t6_stop", {30'b0, cfg_shift}, 32'h0);
    clr_mon();
    mon(10);
    chk("t6_no_more", sh0 + sh1 + set0 + set1, 0);
    rdr(A_STATUS, rd);
    chk("t6_status", rd, 32'h0000_0008);

    // reset mid-transfer
    wr(A_DATA, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h0020_0001);
    mon(5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t7_outs", {26'b0, cfg_data, cfg_shift, cfg_set}, 32'h0);
    clr_mon();
    mon(40);
    chk("t7_quiet", sh0 + sh1 + set0 + set1, 0);
    rdr(A_STATUS, rd);
    chk("t7_status", rd, 32'h0000_0008);

    // decode boundaries
    xfer(1'b0, 32'h3000_0104, 32'h0, 1'b0, rd);
    rdr(32'h3000_0010, rd);
    chk("undef_rd", rd, 32'h0);
    rdr(A_RB, rd);
    chk("readback_rd", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
